dcache_assoc: RTL
=================

# dcache_assoc

Parametrised N-way set-associative, write-back, write-allocate data cache between the Load & Store Buffer and the memory controller. Lookup is one cycle; the cache bypasses memory-mapped IO to the IO port. A miss runs a victim write-back, then a line refill, from an explicit state machine. Naturally aligned byte/half/word accesses are served; misaligned accesses are flagged, never performed.

## Interface
- BLOCK_WIDTH, 4, log2 line bytes; line = 2^BLOCK_WIDTH bytes
- SET_WIDTH, 7, log2 number of sets
- WAY_WIDTH, 1, log2 ways (0..2 supported; 0 = direct-mapped)
- clkIn  input  1  system clock
- resetIn  input  1  reset, asynchronous, active-low
- clearIn  input  1  wrong-branch flush; aborts pending reads
- reqValid  input  1  request present
- reqReady  output  1  high only in IDLE
- reqType  input  2  01 byte, 10 half, 11 word (00 illegal, ignored)
- reqWrite  input  1  1 write, 0 read
- reqAddr  input  32  byte address
- reqData  input  32  write data, low-aligned
- respValid  output  1  read data valid, one-cycle pulse
- respData  output  32  zero-extended read data
- respWriteDone  output  1  write complete, one-cycle pulse
- respMisalign  output  1  misaligned request rejected, one-cycle pulse
- memReq  output  1  memory transaction request
- memWrite  output  1  1 write-back, 0 refill
- memAddr  output  32-BLOCK_WIDTH  line address
- memWriteData  output  8*2^BLOCK_WIDTH  victim line
- memGrant  input  1  write-back accepted (one-cycle pulse)
- memDataValid  input  1  refill line valid (one-cycle pulse)
- memDataIn  input  8*2^BLOCK_WIDTH  refill line
- mmioReq / mmioWrite / mmioType[1:0] / mmioAddr[31:0] / mmioData[31:0]  output  IO access, held until done
- mmioDone  input  1  IO access complete; mmioDataIn[31:0] valid on reads

## Operation
- IO region: reqAddr[17:16]==2'b11. Never cached, never allocated.
- Misaligned: half with addr[0]=1, or word with addr[1:0]!=0. Respond respMisalign next cycle; no state change.
- States: IDLE, WRITEBACK, REFILL, IO, RESPOND.
- IDLE: on accepted request, do a tag compare across all ways of set addr[SET_WIDTH+BLOCK_WIDTH-1:BLOCK_WIDTH].
  - Hit read: respValid with data next cycle.
  - Hit write: merge bytes, set dirty, respWriteDone next cycle.
  - Stay in IDLE; update replacement state.
- Miss: pick victim (invalid way first, lowest index; else replacement policy). Dirty victim → WRITEBACK, else → REFILL.
- WRITEBACK: memReq=1, memWrite=1, victim address/data held stable until memGrant. Then clear dirty and go to REFILL.
- REFILL: memReq=1, memWrite=0 until memDataValid. Then install line (valid=1, tag, dirty=0) and go to RESPOND.
- RESPOND: perform the original access against the installed line (write sets dirty). Pulse the response; return to IDLE.
- IO state: drive mmio* until mmioDone. Then pulse respValid (mmioDataIn) or respWriteDone; return to IDLE.
- clearIn on a pending read, in any state:
  - the response is suppressed;
  - an in-flight WRITEBACK/REFILL still completes and installs;
  - an IO read waits for mmioDone, then drops the data.
- clearIn never aborts writes.
- clearIn in IDLE with a simultaneous request drops that request if it is a read.

## Timing
- Reset (async assert, sync deassert to clkIn):
  - state IDLE; all valid/dirty/replacement bits 0;
  - every output 0 except reqReady=1.
- Hit latency: response exactly 1 cycle after acceptance. Back-to-back hits are sustained at one per cycle.
- Clean-miss latency: memReq rises in cycle after acceptance; response 1 cycle after memDataValid.
- memGrant/memDataValid outside the matching state are ignored.
- Reset mid-miss abandons the transaction. The memory side must tolerate a dropped memReq.

## Configuration
- DCACHE_LRU_EN
  - defined: true LRU via per-way 2-bit age counters per set, updated on every hit and install.
  - undefined: one round-robin pointer per set, advanced on install only.
  - Direct-mapped (WAY_WIDTH=0) ignores both.

## Test plan
- Read word 0x1000 cold, refill line filled with 0xAABBCCDD pattern → one REFILL, respData=0xAABBCCDD; reread → respValid after 1 cycle, no memReq.
- Write byte 0x5A to 0x1003 after fill, then read word 0x1000 → 0x5ABBCCDD; line dirty.
- 2-way: fill sets with tags A, B, touch A, access tag C.
  - LRU_EN: victim B, with a write-back first if B is dirty.
  - Without LRU_EN: victim is the round-robin way.
- Half read at 0x1001 → respMisalign pulse, no memReq, no cache change.
- Read 0x30004, mmioDone after 3 cycles with mmioDataIn=0x41 → respValid, data 0x41; no allocation.
- Read miss, clearIn during REFILL → no respValid; line still installed; next read of same address hits in 1 cycle.

Source files
------------

// File: rtl/dcache_assoc.sv
// dcache_assoc: N-way set-associative, write-back, write-allocate data cache sitting between
// the Load & Store Buffer and the memory controller.
//
// Hits are served with a one-cycle lookup. Addresses with reqAddr[17:16] == 2'b11 bypass the
// cache through the mmio* port. A miss first writes back a dirty victim, then refills the
// line. Misaligned half/word accesses are rejected with respMisalign.
//
// Build option: DCACHE_LRU_EN
//   defined   -> true LRU using 2-bit age counters per way per set (touched on hit and install)
//   undefined -> one round-robin pointer per set, advanced on install only
//
// Ports:
//   clkIn, resetIn (async, active-low), clearIn (wrong-branch flush of pending reads)
//   req*      request from the LSB; reqReady is high only while idle
//   resp*     one-cycle response pulses (read data, write done, misalign)
//   mem*      line-granular memory port (write-back until memGrant, refill until memDataValid)
//   mmio*     IO access, held until mmioDone
module dcache_assoc #(
   parameter int unsigned BLOCK_WIDTH = 4,
   parameter int unsigned SET_WIDTH   = 7,
   parameter int unsigned WAY_WIDTH   = 1
) (
   input  logic                        clkIn,
   input  logic                        resetIn,
   input  logic                        clearIn,
   input  logic                        reqValid,
   output logic                        reqReady,
   input  logic [1:0]                  reqType,
   input  logic                        reqWrite,
   input  logic [31:0]                 reqAddr,
   input  logic [31:0]                 reqData,
   output logic                        respValid,
   output logic [31:0]                 respData,
   output logic                        respWriteDone,
   output logic                        respMisalign,
   output logic                        memReq,
   output logic                        memWrite,
   output logic [31-BLOCK_WIDTH:0]     memAddr,
   output logic [(8<<BLOCK_WIDTH)-1:0] memWriteData,
   input  logic                        memGrant,
   input  logic                        memDataValid,
   input  logic [(8<<BLOCK_WIDTH)-1:0] memDataIn,
   output logic                        mmioReq,
   output logic                        mmioWrite,
   output logic [1:0]                  mmioType,
   output logic [31:0]                 mmioAddr,
   output logic [31:0]                 mmioData,
   input  logic                        mmioDone,
   input  logic [31:0]                 mmioDataIn
);

   localparam int unsigned Ways     = 1 << WAY_WIDTH;
   localparam int unsigned Sets     = 1 << SET_WIDTH;
   localparam int unsigned LineBits = 8 << BLOCK_WIDTH;
   localparam int unsigned TagWidth = 32 - SET_WIDTH - BLOCK_WIDTH;
   localparam int unsigned WayIdxW  = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;

   typedef logic [LineBits-1:0] lineT;
   typedef logic [WayIdxW-1:0]  wayIdxT;
   typedef enum logic [2:0] {StIdle, StWriteback, StRefill, StIo, StRespond} stateT;

   // Storage: line data and tags carry no reset, valid/dirty/replacement state does.
   lineT                dataArr [Ways][Sets];
   logic [TagWidth-1:0] tagArr  [Ways][Sets];
   logic [Ways-1:0]     validQ  [Sets];
   logic [Ways-1:0]     dirtyQ  [Sets];
`ifdef DCACHE_LRU_EN
   logic [1:0]          ageQ    [Sets][Ways];
`else
   wayIdxT              rrQ     [Sets];
`endif

   stateT         stateQ, stateD;
   logic [31:0]   reqAddrQ, reqDataQ;
   logic [1:0]    reqTypeQ;
   logic          reqWriteQ;
   wayIdxT        victimQ, victimD;
   logic          killQ, killD;
   logic          respValidQ, respValidD, respWriteDoneQ, respWriteDoneD;
   logic          respMisalignQ, respMisalignD;
   logic [31:0]   respDataQ, respDataD;

   logic                   capture, dataWe, installEn, setDirty, clrDirty, touchEn;
   logic                   respondRead, respondWrite;
   wayIdxT                 dataWay, touchWay, hitWay, victimWay;
   lineT                   dataLine, hitLine, vicLine;
   logic                   hit, misaligned, isIo, accept;
   logic [31:0]            curAddr;
   logic [SET_WIDTH-1:0]   curSet;
   logic [TagWidth-1:0]    curTag;
   logic [BLOCK_WIDTH-1:0] curOff;

   function automatic logic [31:0] maskData(input logic [31:0] d, input logic [1:0] t);
      logic [31:0] res;
      case (t)
         2'b01:   res = {24'd0, d[7:0]};
         2'b10:   res = {16'd0, d[15:0]};
         default: res = d;
      endcase
      return res;
   endfunction

   function automatic logic [31:0] readLine(input lineT line, input logic [BLOCK_WIDTH-1:0] off,
                                            input logic [1:0] t);
      lineT sh;
      sh = line >> (8 * int'(off));
      return maskData(sh[31:0], t);
   endfunction

   // Write data is low-aligned; bytes land at the access offset within the line.
   function automatic lineT mergeLine(input lineT line, input logic [BLOCK_WIDTH-1:0] off,
                                      input logic [1:0] t, input logic [31:0] d);
      lineT res;
      int   nb;
      nb  = (t == 2'b01) ? 1 : ((t == 2'b10) ? 2 : 4);
      res = line;
      for (int i = 0; i < 4; i++) begin
         if (i < nb) res[8*(int'(off)+i) +: 8] = d[8*i +: 8];
      end
      return res;
   endfunction

   // While idle the lookup uses the live request; afterwards the captured one.
   assign curAddr = (stateQ == StIdle) ? reqAddr : reqAddrQ;
   assign curSet  = curAddr[SET_WIDTH+BLOCK_WIDTH-1:BLOCK_WIDTH];
   assign curTag  = curAddr[31:SET_WIDTH+BLOCK_WIDTH];
   assign curOff  = curAddr[BLOCK_WIDTH-1:0];

   assign misaligned = ((reqType == 2'b10) && reqAddr[0]) ||
                       ((reqType == 2'b11) && (reqAddr[1:0] != 2'b00));
   assign isIo   = (reqAddr[17:16] == 2'b11);
   assign accept = reqValid && (reqType != 2'b00) && !(clearIn && !reqWrite);

   always_comb begin
      hit    = 1'b0;
      hitWay = '0;
      for (int w = 0; w < Ways; w++) begin
         if (validQ[curSet][w] && (tagArr[w][curSet] == curTag)) begin
            hit    = 1'b1;
            hitWay = wayIdxT'(w);
         end
      end
   end

   // Victim: lowest invalid way, otherwise the replacement policy's choice.
   always_comb begin
      logic found;
`ifdef DCACHE_LRU_EN
      logic [1:0] maxAge;
`endif
      found     = 1'b0;
      victimWay = '0;
      for (int w = 0; w < Ways; w++) begin
         if (!found && !validQ[curSet][w]) begin
            found     = 1'b1;
            victimWay = wayIdxT'(w);
         end
      end
`ifdef DCACHE_LRU_EN
      maxAge = ageQ[curSet][0];
      if (!found) begin
         for (int w = 1; w < Ways; w++) begin
            if (ageQ[curSet][w] > maxAge) begin
               maxAge    = ageQ[curSet][w];
               victimWay = wayIdxT'(w);
            end
         end
      end
`else
      if (!found) victimWay = rrQ[curSet];
`endif
   end

   assign hitLine = dataArr[hitWay][curSet];
   assign vicLine = dataArr[victimQ][curSet];

   always_comb begin
      stateD         = stateQ;
      capture        = 1'b0;
      victimD        = victimQ;
      killD          = killQ;
      respValidD     = 1'b0;
      respDataD      = '0;
      respWriteDoneD = 1'b0;
      respMisalignD  = 1'b0;
      dataWe         = 1'b0;
      dataWay        = victimQ;
      dataLine       = '0;
      installEn      = 1'b0;
      setDirty       = 1'b0;
      clrDirty       = 1'b0;
      touchEn        = 1'b0;
      touchWay       = victimQ;
      respondRead    = 1'b0;
      respondWrite   = 1'b0;
      reqReady       = 1'b0;
      memReq         = 1'b0;
      memWrite       = 1'b0;
      memAddr        = '0;
      memWriteData   = '0;
      mmioReq        = 1'b0;
      mmioWrite      = 1'b0;
      mmioType       = 2'b00;
      mmioAddr       = '0;
      mmioData       = '0;
      unique case (stateQ)
         StIdle: begin
            reqReady = 1'b1;
            if (accept) begin
               if (misaligned) begin
                  respMisalignD = 1'b1;
               end else begin
                  capture = 1'b1;
                  killD   = 1'b0;
                  if (isIo) begin
                     stateD = StIo;
                  end else if (hit) begin
                     touchEn  = 1'b1;
                     touchWay = hitWay;
                     if (reqWrite) begin
                        dataWe         = 1'b1;
                        dataWay        = hitWay;
                        dataLine       = mergeLine(hitLine, curOff, reqType, reqData);
                        setDirty       = 1'b1;
                        respWriteDoneD = 1'b1;
                     end else begin
                        respValidD = 1'b1;
                        respDataD  = readLine(hitLine, curOff, reqType);
                     end
                  end else begin
                     victimD = victimWay;
                     stateD  = (validQ[curSet][victimWay] && dirtyQ[curSet][victimWay]) ?
                               StWriteback : StRefill;
                  end
               end
            end
         end
         StWriteback: begin
            memReq       = 1'b1;
            memWrite     = 1'b1;
            memAddr      = {tagArr[victimQ][curSet], curSet};
            memWriteData = vicLine;
            if (memGrant) begin
               clrDirty = 1'b1;
               stateD   = StRefill;
            end
         end
         StRefill: begin
            memReq  = 1'b1;
            memAddr = reqAddrQ[31:BLOCK_WIDTH];
            if (memDataValid) begin
               dataWe    = 1'b1;
               dataLine  = memDataIn;
               installEn = 1'b1;
               touchEn   = 1'b1;
               stateD    = StRespond;
            end
         end
         StRespond: begin
            if (reqWriteQ) begin
               dataWe       = 1'b1;
               dataLine     = mergeLine(vicLine, curOff, reqTypeQ, reqDataQ);
               setDirty     = 1'b1;
               respondWrite = 1'b1;
            end else begin
               respondRead = !killQ && !clearIn;
            end
            stateD = StIdle;
         end
         StIo: begin
            mmioReq   = 1'b1;
            mmioWrite = reqWriteQ;
            mmioType  = reqTypeQ;
            mmioAddr  = reqAddrQ;
            mmioData  = reqDataQ;
            if (mmioDone) begin
               if (reqWriteQ) begin
                  respWriteDoneD = 1'b1;
               end else if (!killQ && !clearIn) begin
                  respValidD = 1'b1;
                  respDataD  = maskData(mmioDataIn, reqTypeQ);
               end
               stateD = StIdle;
            end
         end
         default: stateD = StIdle;
      endcase
      // A flush only cancels the response of a pending read; the transaction itself runs on.
      if ((stateQ != StIdle) && clearIn && !reqWriteQ) killD = 1'b1;
   end

   assign respValid     = respValidQ | respondRead;
   assign respData      = respondRead ? readLine(vicLine, curOff, reqTypeQ) : respDataQ;
   assign respWriteDone = respWriteDoneQ | respondWrite;
   assign respMisalign  = respMisalignQ;

   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         stateQ         <= StIdle;
         reqAddrQ       <= '0;
         reqDataQ       <= '0;
         reqTypeQ       <= 2'b00;
         reqWriteQ      <= 1'b0;
         victimQ        <= '0;
         killQ          <= 1'b0;
         respValidQ     <= 1'b0;
         respDataQ      <= '0;
         respWriteDoneQ <= 1'b0;
         respMisalignQ  <= 1'b0;
      end else begin
         stateQ         <= stateD;
         victimQ        <= victimD;
         killQ          <= killD;
         respValidQ     <= respValidD;
         respDataQ      <= respDataD;
         respWriteDoneQ <= respWriteDoneD;
         respMisalignQ  <= respMisalignD;
         if (capture) begin
            reqAddrQ  <= reqAddr;
            reqDataQ  <= reqData;
            reqTypeQ  <= reqType;
            reqWriteQ <= reqWrite;
         end
      end
   end

   always_ff @(posedge clkIn or negedge resetIn) begin
      if (!resetIn) begin
         for (int s = 0; s < Sets; s++) begin
            validQ[s] <= '0;
            dirtyQ[s] <= '0;
`ifdef DCACHE_LRU_EN
            for (int w = 0; w < Ways; w++) ageQ[s][w] <= 2'd0;
`else
            rrQ[s] <= '0;
`endif
         end
      end else begin
         if (installEn) begin
            validQ[curSet][victimQ] <= 1'b1;
            dirtyQ[curSet][victimQ] <= 1'b0;
         end
         if (clrDirty) dirtyQ[curSet][victimQ] <= 1'b0;
         if (setDirty) dirtyQ[curSet][dataWay] <= 1'b1;
`ifdef DCACHE_LRU_EN
         // Touched way becomes youngest; ways not older than it age by one (saturating).
         if (touchEn) begin
            for (int v = 0; v < Ways; v++) begin
               if (wayIdxT'(v) == touchWay) begin
                  ageQ[curSet][v] <= 2'd0;
               end else if ((ageQ[curSet][v] <= ageQ[curSet][touchWay]) &&
                            (ageQ[curSet][v] != 2'd3)) begin
                  ageQ[curSet][v] <= ageQ[curSet][v] + 2'd1;
               end
            end
         end
`else
         if (installEn && (Ways > 1)) rrQ[curSet] <= rrQ[curSet] + wayIdxT'(1);
`endif
      end
   end

   always_ff @(posedge clkIn) begin
      if (dataWe)    dataArr[dataWay][curSet] <= dataLine;
      if (installEn) tagArr[victimQ][curSet]  <= curTag;
   end

endmodule
